// File: rtl/bram_1rw_be_pkg.sv
// bram_1rw_be_pkg: shared encodings for the byte-strobed 1RW BRAM.
// Write-mode codes and clear-sweep FSM states.
package bram_1rw_be_pkg;

  localparam int WM_READ_FIRST  = 0;
  localparam int WM_WRITE_FIRST = 1;
  localparam int WM_NO_CHANGE   = 2;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } clr_state_e;

endpackage

// File: rtl/bram_1rw_be_if.sv
// bram_1rw_be_if: request/response bundle between
// the cache controller (master) and the BRAM (slave).
interface bram_1rw_be_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 64,
  parameter int BYTE_WIDTH = 8
);
  localparam int NB = DATA_WIDTH / BYTE_WIDTH;

  logic                  ena;
  logic [NB-1:0]         wea;
  logic [ADDR_WIDTH-1:0] addra;
  logic [DATA_WIDTH-1:0] dina;
  logic [DATA_WIDTH-1:0] douta;
  logic                  douta_valid;
  logic                  rdya;

  modport master (
    output ena, wea, addra, dina,
    input  douta, douta_valid, rdya
  );

  modport slave (
    input  ena, wea, addra, dina,
    output douta, douta_valid, rdya
  );
endinterface

// File: rtl/bram_1rw_be_clear_fsm.sv
// bram_clear_fsm: post-reset zeroing sweep, one word
// per cycle, then holds READY until the next reset.
module bram_clear_fsm
  import bram_1rw_be_pkg::*;
#(
  parameter int ADDR_WIDTH     = 6,
  parameter int MEMSIZE        = 64,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  clr_we_o,
  output logic [ADDR_WIDTH-1:0] clr_addr_o,
  output logic                  rdy_o
);
  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(MEMSIZE - 1);
  localparam clr_state_e ST_INIT =
    (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

  clr_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_we_o = 1'b0;
    rdy_o    = 1'b0;
    unique case (state_q)
      ST_CLEAR: begin
        clr_we_o = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end
      end
      ST_READY: rdy_o = 1'b1;
    endcase
  end

  assign clr_addr_o = cnt_q;

endmodule

// File: rtl/bram_1rw_be.sv
// bram_1rw_be: single-port BRAM with byte strobes,
// read-during-write mode and 1/2-cycle read latency.
module bram_1rw_be
  import bram_1rw_be_pkg::*;
#(
  parameter int ADDR_WIDTH     = 6,
  parameter int DATA_WIDTH     = 64,
  parameter int BYTE_WIDTH     = 8,
  parameter int MEMSIZE        = 64,
  parameter int WRITE_MODE     = 0,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic          clka,
  input logic          rsta,
  bram_1rw_be_if.slave bus
);
  localparam int NB = DATA_WIDTH / BYTE_WIDTH;
  localparam int BW = BYTE_WIDTH;
  localparam logic [ADDR_WIDTH:0] LIM = MEMSIZE[ADDR_WIDTH:0];
  localparam bit M_RF = WRITE_MODE == WM_READ_FIRST;
  localparam bit M_WF = WRITE_MODE == WM_WRITE_FIRST;
  localparam bit M_NC = WRITE_MODE == WM_NO_CHANGE;

  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_err_bw
    $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_err_rl
    $error("READ_LATENCY must be 1 or 2");
  end
  if (WRITE_MODE > 2 || WRITE_MODE < 0) begin : g_err_wm
    $error("WRITE_MODE must be 0, 1 or 2");
  end
  if (MEMSIZE > (1 << ADDR_WIDTH)) begin : g_err_ms
    $error("MEMSIZE exceeds address space");
  end

  logic [DATA_WIDTH-1:0] ram [MEMSIZE];

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  rdy;
  logic                  acc, is_wr, in_rng;
  logic [DATA_WIDTH-1:0] old_w, new_w;
  logic [DATA_WIDTH-1:0] d1_q, d1_d;
  logic                  v1_q, v1_d;

  bram_clear_fsm #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .MEMSIZE       (MEMSIZE),
    .CLEAR_ON_RESET(CLEAR_ON_RESET)
  ) u_clr (
    .clk_i     (clka),
    .rst_i     (rsta),
    .clr_we_o  (clr_we),
    .clr_addr_o(clr_addr),
    .rdy_o     (rdy)
  );

  assign bus.rdya = rdy;
  assign acc      = bus.ena & rdy & ~rsta;
  assign is_wr    = |bus.wea;
  assign in_rng   = {1'b0, bus.addra} < LIM;
  assign old_w    = in_rng ? ram[bus.addra] : '0;

  always_comb begin
    new_w = old_w;
    for (int i = 0; i < NB; i++) begin
      if (bus.wea[i]) new_w[i*BW +: BW] = bus.dina[i*BW +: BW];
    end
  end

  // Sweep owns the array until rdya rises
  always_ff @(posedge clka) begin
    if (clr_we) begin
      ram[clr_addr] <= '0;
    end else if (acc && is_wr && in_rng) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.wea[i])
          ram[bus.addra][i*BW +: BW] <= bus.dina[i*BW +: BW];
      end
    end
  end

  always_comb begin
    v1_d = 1'b0;
    d1_d = d1_q;
    if (acc) begin
      unique case (1'b1)
        !is_wr: begin
          v1_d = 1'b1;
          d1_d = old_w;
        end
        is_wr && M_RF: begin
          v1_d = 1'b1;
          d1_d = old_w;
        end
        is_wr && M_WF: begin
          v1_d = 1'b1;
          d1_d = in_rng ? new_w : '0;
        end
        is_wr && M_NC: v1_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      v1_q <= 1'b0;
      d1_q <= '0;
    end else begin
      v1_q <= v1_d;
      d1_q <= d1_d;
    end
  end

  if (READ_LATENCY == 2) begin : g_rl2
    logic [DATA_WIDTH-1:0] d2_q;
    logic                  v2_q;

    always_ff @(posedge clka) begin
      if (rsta) begin
        v2_q <= 1'b0;
        d2_q <= '0;
      end else begin
        v2_q <= v1_q;
        if (v1_q) d2_q <= d1_q;
      end
    end

    assign bus.douta       = d2_q;
    assign bus.douta_valid = v2_q;
  end else begin : g_rl1
    assign bus.douta       = d1_q;
    assign bus.douta_valid = v1_q;
  end

endmodule

// File: tb/tb_bram_1rw_be.sv
// tb_bram_1rw_be: directed checks over five configurations
// (RF, WF, NC, RL2/MEMSIZE12, no-clear) sharing one stimulus bus.
module tb_bram_1rw_be;
  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [4:0]  sel;
  logic [3:0]  wea;
  logic [3:0]  addra;
  logic [31:0] dina;

  logic [4:0][31:0] dout;
  logic [4:0]       vld;
  logic [4:0]       rdy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    localparam int WM = (g == 1) ? 1 : (g == 2) ? 2 : 0;
    localparam int RL = (g == 3) ? 2 : 1;
    localparam int MS = (g == 3) ? 12 : 16;
    localparam int CR = (g == 4) ? 0 : 1;

    bram_1rw_be_if #(
      .ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8)
    ) bif ();

    bram_1rw_be #(
      .ADDR_WIDTH    (4),
      .DATA_WIDTH    (32),
      .BYTE_WIDTH    (8),
      .MEMSIZE       (MS),
      .WRITE_MODE    (WM),
      .READ_LATENCY  (RL),
      .CLEAR_ON_RESET(CR)
    ) u_dut (
      .clka(clk),
      .rsta(rst),
      .bus (bif)
    );

    assign bif.ena   = ena & sel[g];
    assign bif.wea   = wea;
    assign bif.addra = addra;
    assign bif.dina  = dina;
    assign dout[g]   = bif.douta;
    assign vld[g]    = bif.douta_valid;
    assign rdy[g]    = bif.rdya;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [4:0] s, input logic [3:0] a,
                    input logic [31:0] d, input logic [3:0] w);
    sel = s; addra = a; dina = d; wea = w; ena = 1'b1;
    tick();
    ena = 1'b0; wea = 4'h0;
  endtask

  task automatic rd(input int u, input logic [3:0] a,
                    input logic [31:0] exp, input string tag);
    go(5'(1 << u), a, 32'h0, 4'h0);
    if (u == 3) tick();
    check({tag, "_v"}, 32'(vld[u]), 32'h1);
    check(tag, dout[u], exp);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", n_chk);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ena = 1'b0; sel = 5'h0;
    wea = 4'h0; addra = 4'h0; dina = 32'h0;
    tick(); tick();
    rst = 1'b0;
    check("rst_vld", 32'(vld), 32'h0);
    check("rst_dout0", dout[0], 32'h0);
    check("rst_rdy", 32'(rdy), 32'h10);

    // 1: sweep timing, writes during sweep ignored
    for (int k = 1; k <= 16; k++) begin
      sel = 5'b00111; ena = 1'b1; wea = 4'hF;
      addra = 4'(k - 1); dina = 32'hDEADBEEF;
      tick();
      check("sweep_rdy0", 32'(rdy[0]), 32'(k >= 16));
      check("sweep_rdy3", 32'(rdy[3]), 32'(k >= 12));
      check("sweep_rdy4", 32'(rdy[4]), 32'h1);
      check("sweep_vld", 32'(vld[2:0]), 32'h0);
    end
    ena = 1'b0; wea = 4'h0;
    for (int a = 0; a < 16; a++) rd(0, 4'(a), 32'h0, "clr_rd");

    // 2: byte strobes
    go(5'b00001, 4'd3, 32'hAABBCCDD, 4'hF);
    go(5'b00001, 4'd3, 32'h11223344, 4'b0101);
    rd(0, 4'd3, 32'hAA22CC44, "be_merge");

    // 3: read-during-write modes
    go(5'b00111, 4'd5, 32'h12345678, 4'hF);
    for (int u = 0; u < 3; u++) rd(u, 4'd5, 32'h12345678, "wm_pre");
    go(5'b00111, 4'd5, 32'hFFFFFFFF, 4'hF);
    check("rf_v", 32'(vld[0]), 32'h1);
    check("rf_d", dout[0], 32'h12345678);
    check("wf_v", 32'(vld[1]), 32'h1);
    check("wf_d", dout[1], 32'hFFFFFFFF);
    check("nc_v", 32'(vld[2]), 32'h0);
    check("nc_d", dout[2], 32'h12345678);
    rd(2, 4'd5, 32'hFFFFFFFF, "nc_wr");

    // no-clear instance usable straight away
    go(5'b10000, 4'd7, 32'hCAFEF00D, 4'hF);
    check("noclr_wv", 32'(vld[4]), 32'h1);
    rd(4, 4'd7, 32'hCAFEF00D, "noclr_rd");

    // 4: latency 2, back-to-back reads
    go(5'b01000, 4'd0, 32'hA0A0A0A0, 4'hF);
    go(5'b01000, 4'd1, 32'hB1B1B1B1, 4'hF);
    go(5'b01000, 4'd2, 32'hC2C2C2C2, 4'hF);
    tick(); tick();
    sel = 5'b01000; ena = 1'b1; wea = 4'h0;
    addra = 4'd0; tick();
    check("rl2_c1_v", 32'(vld[3]), 32'h0);
    addra = 4'd1; tick();
    check("rl2_c2_v", 32'(vld[3]), 32'h1);
    check("rl2_c2_d", dout[3], 32'hA0A0A0A0);
    addra = 4'd2; tick();
    check("rl2_c3_v", 32'(vld[3]), 32'h1);
    check("rl2_c3_d", dout[3], 32'hB1B1B1B1);
    ena = 1'b0; tick();
    check("rl2_c4_v", 32'(vld[3]), 32'h1);
    check("rl2_c4_d", dout[3], 32'hC2C2C2C2);
    tick();
    check("rl2_c5_v", 32'(vld[3]), 32'h0);
    check("rl2_hold", dout[3], 32'hC2C2C2C2);

    // 5: reset drops in-flight read; mid-sweep restart
    go(5'b00001, 4'd10, 32'h10101010, 4'hF);
    rd(0, 4'd10, 32'h10101010, "pre5");
    sel = 5'b01000; addra = 4'd0; wea = 4'h0; ena = 1'b1;
    tick();
    ena = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("drop_v", 32'(vld[3]), 32'h0);
    check("drop_d", dout[3], 32'h0);
    for (int k = 1; k <= 7; k++) begin
      tick();
      check("drop_v_sweep", 32'(vld[3]), 32'h0);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check("rst2_rdy0", 32'(rdy[0]), 32'(k >= 16));
      check("rst2_rdy3", 32'(rdy[3]), 32'(k >= 12));
    end
    rd(0, 4'd10, 32'h0, "restart_clr");

    // 6: top in-range address and out-of-range accesses
    rd(0, 4'd15, 32'h0, "a15_rd");
    go(5'b00001, 4'd15, 32'h0F0F0F0F, 4'hF);
    check("a15_wr_v", 32'(vld[0]), 32'h1);
    check("a15_wr_d", dout[0], 32'h0);
    rd(0, 4'd15, 32'h0F0F0F0F, "a15_rd2");
    go(5'b01000, 4'd11, 32'h5A5A5A5A, 4'hF);
    tick(); tick();
    rd(3, 4'd11, 32'h5A5A5A5A, "m12_a11");
    rd(3, 4'd13, 32'h0, "oor_rd");
    go(5'b01000, 4'd13, 32'hFFFFFFFF, 4'hF);
    tick();
    check("oor_wr_v", 32'(vld[3]), 32'h1);
    check("oor_wr_d", dout[3], 32'h0);
    tick();
    for (int a = 0; a < 12; a++)
      rd(3, 4'(a), (a == 11) ? 32'h5A5A5A5A : 32'h0, "oor_keep");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_1rw_be.md
Name: bram_1rw_be

Overview:
- Parametrised single-port block RAM for the cache and tag arrays. It is the successor to the plain 1RW BRAM.
- Adds per-byte write strobes and a selectable read-during-write mode.
- Adds a configurable read latency of 1 or 2 cycles, with a douta_valid qualifier.
- Adds an optional hardware clear sweep after reset, with a ready flag.
- Sits between the cache controller and the storage array; synthesises to inferred block RAM.

Parameters:
- ADDR_WIDTH, 6, address bits.
- DATA_WIDTH, 64, word width; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8, bits per write strobe.
- MEMSIZE, 64, number of words; must be <= 2**ADDR_WIDTH.
- WRITE_MODE, 0, behaviour on a write: 0 = READ_FIRST, 1 = WRITE_FIRST, 2 = NO_CHANGE.
- READ_LATENCY, 1, 1 = array register only; 2 = adds an output register.
- CLEAR_ON_RESET, 1, 1 = zero the whole array after reset; 0 = no sweep.

Ports:
- clka  in  1  clock; single clock domain.
- rsta  in  1  reset, synchronous, active-high.
- ena  in  1  request enable; sampled only when rdya=1.
- wea  in  DATA_WIDTH/BYTE_WIDTH  per-byte write strobes; all zero means read.
- addra  in  ADDR_WIDTH  word address.
- dina  in  DATA_WIDTH  write data.
- douta  out  DATA_WIDTH  read data; holds its value between valid pulses.
- douta_valid  out  1  one-cycle pulse marking new douta.
- rdya  out  1  array accepts requests.

Behaviour:
- Reset (rsta=1 at a clka edge):
  - douta=0, douta_valid=0, pipeline stages cleared.
  - In-flight reads are dropped; no valid pulse appears for them.
  - rdya=0 if CLEAR_ON_RESET=1, else rdya=1 from the first cycle after reset.
  - Array contents are not altered by reset itself.
- Clear FSM, states CLEAR and READY:
  - rsta forces state CLEAR and clear counter 0.
  - In CLEAR, one word per cycle: ram[cnt]=0, cnt++.
  - At cnt==MEMSIZE-1 the word is written and the FSM moves to READY.
  - rdya=1 exactly MEMSIZE cycles after rsta deasserts.
  - rsta asserted mid-sweep restarts the sweep from 0.
  - With CLEAR_ON_RESET=0 the FSM is held in READY.
- Request acceptance: a request is accepted when ena=1 and rdya=1. ena while rdya=0 is ignored; no write, no valid.
- Read (wea==0):
  - douta = ram[addra], with douta_valid=1, READ_LATENCY cycles after the accept edge.
  - Back-to-back reads give one result per cycle.
- Write (wea!=0):
  - Byte i of ram[addra] takes dina byte i only where wea[i]=1; other bytes are unchanged.
  - READ_FIRST: the old word is returned with a valid pulse, at read latency.
  - WRITE_FIRST: the merged new word is returned with a valid pulse.
  - NO_CHANGE: douta holds and no valid pulse is produced.
- Address >= MEMSIZE: the write is dropped. A read returns 0 and still gets a valid pulse, to keep pipeline accounting.
- Read after write to the same address on the next cycle returns the new data. There is no hazard, because there is a single port.
- READ_LATENCY=2: the second register loads only when the stage-1 valid is set, so douta holds otherwise.
- Elaboration errors:
  - DATA_WIDTH % BYTE_WIDTH != 0.
  - READ_LATENCY not 1 or 2.
  - WRITE_MODE > 2.
  - MEMSIZE > 2**ADDR_WIDTH.
- No simulation init block. Contents are defined by the clear sweep, or are X when CLEAR_ON_RESET=0.

Decomposition:
- Shared header bram_defs:
  - WRITE_MODE encodings: WM_READ_FIRST=0, WM_WRITE_FIRST=1, WM_NO_CHANGE=2.
  - Clear FSM state encodings: ST_CLEAR, ST_READY.
- Sub-module bram_clear_fsm:
  - Contains the counter and state.
  - Outputs clr_we, clr_addr and rdya.
  - The top level muxes it ahead of the user port.

Test Plan (DATA_WIDTH=32, BYTE_WIDTH=8, MEMSIZE=16, ADDR_WIDTH=4):
1. Release rsta, hold ena=1 during the sweep, then read all 16 addresses -> rdya rises exactly 16 cycles after reset release; every read returns 0x00000000; the writes attempted during the sweep have no effect.
2. Byte strobes: write 0xAABBCCDD with wea=4'hF to addr 3, then 0x11223344 with wea=4'b0101, then read addr 3 -> 0xAA22CC44.
3. WRITE_MODE sweep: with ram[5]=0x12345678, write 0xFFFFFFFF, wea=4'hF -> READ_FIRST returns 0x12345678 with valid; WRITE_FIRST returns 0xFFFFFFFF with valid; NO_CHANGE gives no valid pulse and douta unchanged.
4. READ_LATENCY=2, back-to-back reads of addrs 0,1,2 in consecutive cycles -> three consecutive valid pulses starting 2 cycles after the first accept, with data in order.
5. Assert rsta while a read is in flight, and again at cnt=7 of the sweep -> no valid pulse for the dropped read; the sweep restarts; rdya rises 16 cycles after the last reset release.
6. Read addr 15 then write addr 15 (in range); with MEMSIZE=12, read addr 13 -> that read returns 0 with valid, and a write to addr 13 leaves addrs 0-11 unchanged.
